// File: rtl/ahb_uart_gen2.sv
// ---------------------------------------------------------------------------
// ahb_uart_gen2 -- AHB-Lite slave UART with TX/RX FIFOs.
//
// Zero-wait-state AHB-Lite register block in front of an 8-bit UART with
// 16x oversampling, optional parity and one stop bit.
//
// Register map (haddr[3:2]):
//   0 DATA   W: push hwdata[7:0] to TX FIFO   R: pop RX FIFO (0 when empty)
//   1 STATUS [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//            [4] overrun [5] parity_err [6] frame_err (sticky, W1C) [7] tx_busy
//   2 CTRL   [0] tx_en [1] rx_en [2] parity_en [3] parity_odd
//            [4] irq_rx_en [5] irq_tx_en
//   3 DIV    [15:0] baud divider, one tick every DIV+1 hclk cycles
//
// Ports:
//   hclk, hresetn              clock, asynchronous active-low reset
//   hsel_i .. hwdata_i         AHB-Lite slave inputs (hsize_i ignored)
//   hreadyout_o, hresp_o       tied ready / OKAY
//   hrdata_o                   read data, valid during read data phases
//   tx, rx                     serial line out / in (rx is asynchronous)
//   irq_o                      level interrupt
// ---------------------------------------------------------------------------
module ahb_uart_gen2 #(
  parameter int          AWIDTH    = 32,
  parameter int          DWIDTH    = 32,
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DIV_RESET = 16'd26
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel_i,
  input  logic              hwrite_i,
  input  logic              hready_i,
  input  logic [2:0]        hsize_i,
  input  logic [1:0]        htrans_i,
  input  logic [AWIDTH-1:0] haddr_i,
  input  logic [DWIDTH-1:0] hwdata_i,
  output logic              hreadyout_o,
  output logic              hresp_o,
  output logic [DWIDTH-1:0] hrdata_o,
  output logic              tx,
  input  logic              rx,
  output logic              irq_o
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;
  localparam logic [PW-1:0] PTR_WRAP = {1'b1, {AW{1'b0}}};

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_DIV  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP
  } uart_state_e;

  // Only word accesses exist, so size, the low address bits and the upper
  // write-data bits carry no information for this block.
  logic unused;
  assign unused = ^{hsize_i, htrans_i[0], haddr_i, hwdata_i};

  assign hreadyout_o = 1'b1;
  assign hresp_o     = 1'b0;

  // -------------------------------------------------------------------------
  // AHB address/data phase pipeline
  // -------------------------------------------------------------------------
  logic       dp_valid, dp_write;
  logic [1:0] dp_addr;

  // NOTE: clocked state is always assigned with <= so every flop samples
  // the pre-edge value of its inputs, regardless of statement order.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= 2'd0;
    end else begin
      dp_valid <= hsel_i & hready_i & htrans_i[1];
      if (hsel_i & hready_i & htrans_i[1]) begin
        dp_write <= hwrite_i;
        dp_addr  <= haddr_i[3:2];
      end
    end
  end

  logic wr_data, wr_stat, wr_ctrl, wr_div, rd_data;
  assign wr_data = dp_valid &  dp_write & (dp_addr == A_DATA);
  assign wr_stat = dp_valid &  dp_write & (dp_addr == A_STAT);
  assign wr_ctrl = dp_valid &  dp_write & (dp_addr == A_CTRL);
  assign wr_div  = dp_valid &  dp_write & (dp_addr == A_DIV);
  assign rd_data = dp_valid & ~dp_write & (dp_addr == A_DATA);

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  logic [5:0]  ctrl_q;
  logic [15:0] div_q;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ctrl_q <= 6'h03;
      div_q  <= DIV_RESET;
    end else begin
      if (wr_ctrl) ctrl_q <= hwdata_i[5:0];
      if (wr_div)  div_q  <= hwdata_i[15:0];
    end
  end

  // -------------------------------------------------------------------------
  // Baud divider: tick when the counter is 0, then reload from DIV
  // -------------------------------------------------------------------------
  logic [15:0] div_cnt;
  logic        tick;
  assign tick = (div_cnt == 16'd0);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)  div_cnt <= 16'd0;
    else if (tick) div_cnt <= div_q;
    else           div_cnt <= div_cnt - 16'd1;
  end

  // -------------------------------------------------------------------------
  // FIFOs: extra pointer MSB distinguishes full from empty
  // -------------------------------------------------------------------------
  logic [7:0]    tx_mem [DEPTH];
  logic [7:0]    rx_mem [DEPTH];
  logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_push, tx_pop, rx_push, rx_pop;
  logic [7:0]    rx_shift;

  assign tx_empty = (tx_wptr == tx_rptr);
  assign tx_full  = ((tx_wptr ^ tx_rptr) == PTR_WRAP);
  assign rx_empty = (rx_wptr == rx_rptr);
  assign rx_full  = ((rx_wptr ^ rx_rptr) == PTR_WRAP);

  assign tx_push = wr_data & ~tx_full;
  assign rx_pop  = rd_data & ~rx_empty;

  // NOTE: FIFO storage has no reset; the pointers alone define validity, and
  // leaving the array reset-free lets it map onto plain RAM/register files.
  always_ff @(posedge hclk) begin
    if (tx_push) tx_mem[tx_wptr[AW-1:0]] <= hwdata_i[7:0];
    if (rx_push) rx_mem[rx_wptr[AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      rx_wptr <= '0;
      rx_rptr <= '0;
    end else begin
      if (tx_push) tx_wptr <= tx_wptr + PW'(1);
      if (tx_pop)  tx_rptr <= tx_rptr + PW'(1);
      if (rx_push) rx_wptr <= rx_wptr + PW'(1);
      if (rx_pop)  rx_rptr <= rx_rptr + PW'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Transmitter
  // -------------------------------------------------------------------------
  uart_state_e tx_state, tx_state_d;
  logic [3:0]  tx_tcnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift;
  logic        tx_par, tx_bit_end, tx_busy;

  assign tx_bit_end = tick & (tx_tcnt == 4'd15);
  assign tx_pop     = (tx_state == ST_IDLE) & tick & ctrl_q[0] & ~tx_empty;
  assign tx_busy    = (tx_state != ST_IDLE);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) tx_state <= ST_IDLE;
    else          tx_state <= tx_state_d;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    tx_state_d = tx_state;
    tx         = 1'b1;
    unique case (tx_state)
      ST_IDLE:   if (tx_pop) tx_state_d = ST_START;
      ST_START: begin
        tx = 1'b0;
        if (tx_bit_end) tx_state_d = ST_DATA;
      end
      ST_DATA: begin
        tx = tx_shift[0];
        if (tx_bit_end && tx_bit == 3'd7)
          tx_state_d = ctrl_q[2] ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx = tx_par;
        if (tx_bit_end) tx_state_d = ST_STOP;
      end
      ST_STOP:   if (tx_bit_end) tx_state_d = ST_IDLE;
      default:   tx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      tx_tcnt  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'd0;
      tx_par   <= 1'b0;
    end else if (tx_state == ST_IDLE) begin
      tx_tcnt <= 4'd0;
      tx_bit  <= 3'd0;
      if (tx_pop) begin
        tx_shift <= tx_mem[tx_rptr[AW-1:0]];
        tx_par   <= (^tx_mem[tx_rptr[AW-1:0]]) ^ ctrl_q[3];
      end
    end else if (tick) begin
      tx_tcnt <= tx_tcnt + 4'd1;
      if (tx_bit_end && tx_state == ST_DATA) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Receiver: two-flop synchroniser plus one history flop for edge detect
  // -------------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_s3;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  uart_state_e rx_state, rx_state_d;
  logic [3:0]  rx_tcnt;
  logic [2:0]  rx_bit;
  logic        rx_perr, rx_sample, rx_bit_end, rx_fall;
  logic        rx_done, rx_push_req;

  assign rx_fall    = rx_s3 & ~rx_s2;
  assign rx_sample  = tick & (rx_tcnt == 4'd7);
  assign rx_bit_end = tick & (rx_tcnt == 4'd15);

  // The frame ends at the stop-bit sample so a back-to-back start edge is
  // never missed while waiting out the second half of the stop bit.
  assign rx_done     = (rx_state == ST_STOP) & rx_sample;
  assign rx_push_req = rx_done & rx_s2;
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) rx_state <= ST_IDLE;
    else          rx_state <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state;
    unique case (rx_state)
      ST_IDLE:   if (ctrl_q[1] && rx_fall) rx_state_d = ST_START;
      ST_START: begin
        if (rx_sample && rx_s2) rx_state_d = ST_IDLE;   // glitch, not a start
        else if (rx_bit_end)    rx_state_d = ST_DATA;
      end
      ST_DATA:
        if (rx_bit_end && rx_bit == 3'd7)
          rx_state_d = ctrl_q[2] ? ST_PARITY : ST_STOP;
      ST_PARITY: if (rx_bit_end) rx_state_d = ST_STOP;
      ST_STOP:   if (rx_sample)  rx_state_d = ST_IDLE;
      default:   rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      rx_tcnt  <= 4'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'd0;
      rx_perr  <= 1'b0;
    end else if (rx_state == ST_IDLE) begin
      rx_tcnt <= 4'd0;
      rx_bit  <= 3'd0;
      rx_perr <= 1'b0;
    end else if (tick) begin
      rx_tcnt <= rx_tcnt + 4'd1;
      if (rx_state == ST_DATA && rx_sample)   rx_shift <= {rx_s2, rx_shift[7:1]};
      if (rx_state == ST_DATA && rx_bit_end)  rx_bit   <= rx_bit + 3'd1;
      if (rx_state == ST_PARITY && rx_sample) rx_perr  <= rx_s2 ^ (^rx_shift) ^ ctrl_q[3];
    end
  end

  // -------------------------------------------------------------------------
  // Sticky status flags: a hardware set wins over a same-cycle W1C
  // -------------------------------------------------------------------------
  logic ovr_q, perr_q, ferr_q;
  logic ovr_set, perr_set, ferr_set;

  assign ovr_set  = rx_push_req & rx_full & ~rx_pop;
  assign perr_set = rx_push_req & rx_perr;
  assign ferr_set = rx_done & ~rx_s2;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ovr_q  <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovr_q  <= ovr_set  | (ovr_q  & ~(wr_stat & hwdata_i[4]));
      perr_q <= perr_set | (perr_q & ~(wr_stat & hwdata_i[5]));
      ferr_q <= ferr_set | (ferr_q & ~(wr_stat & hwdata_i[6]));
    end
  end

  logic [7:0] status;
  assign status = {tx_busy, ferr_q, perr_q, ovr_q, rx_empty, rx_full, tx_empty, tx_full};

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) irq_o <= 1'b0;
    else          irq_o <= (ctrl_q[4] & ~rx_empty) | (ctrl_q[5] & tx_empty & ~tx_busy);
  end

  // -------------------------------------------------------------------------
  // Read data, driven only during a read data phase
  // -------------------------------------------------------------------------
  always_comb begin
    hrdata_o = '0;
    if (dp_valid && !dp_write) begin
      unique case (dp_addr)
        A_DATA: if (!rx_empty) hrdata_o[7:0] = rx_mem[rx_rptr[AW-1:0]];
        A_STAT: hrdata_o[7:0]  = status;
        A_CTRL: hrdata_o[5:0]  = ctrl_q;
        A_DIV:  hrdata_o[15:0] = div_q;
        default: hrdata_o = '0;
      endcase
    end
  end

endmodule
